hex_dumper: RTL and testbench



---
 rtl/hex_dumper.sv | 266 ++++++++++++++++++++++++++
 tb/tb_hex_dumper.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_dumper.sv
// ============================================================================
// Module      : hex_dumper
// Description : Streams a memory byte range out as uppercase ASCII Intel HEX
//               records over a valid/ready byte stream, closed by an EOF record.
//               Optional macro HEX_DUMPER_CRLF_EN selects CR LF line endings
//               (LF only when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_dumper #(
    parameter int ADDR_W  = 15,
    parameter int REC_LEN = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0]  c_CH_COLON  = 8'h3A;
    localparam logic [7:0]  c_CH_ZERO   = 8'h30;
    localparam logic [7:0]  c_CH_ONE    = 8'h31;
    localparam logic [7:0]  c_CH_CR     = 8'h0D;
    localparam logic [7:0]  c_CH_LF     = 8'h0A;
    localparam logic [16:0] c_REC_LEN17 = 17'(REC_LEN);
    localparam logic [7:0]  c_REC_LEN8  = 8'(REC_LEN);

    typedef enum logic [4:0] {
        IDLE   = 5'd0,
        COLON  = 5'd1,
        LEN_H  = 5'd2,
        LEN_L  = 5'd3,
        ADR3   = 5'd4,
        ADR2   = 5'd5,
        ADR1   = 5'd6,
        ADR0   = 5'd7,
        TYP_H  = 5'd8,
        TYP_L  = 5'd9,
        DAT_H  = 5'd10,
        DAT_L  = 5'd11,
        CHK_H  = 5'd12,
        CHK_L  = 5'd13,
        EOL_CR = 5'd14,
        EOL_LF = 5'd15,
        FIN    = 5'd16
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              addr_stable_q, addr_stable_d;
    logic [7:0]        pf_q, pf_d;
    logic              pf_valid_q, pf_valid_d;
    logic [7:0]        cur_q, cur_d;
    logic [7:0]        rec_cnt_q, rec_cnt_d;
    logic [7:0]        ll_q, ll_d;
    logic              eof_q, eof_d;
    logic [7:0]        csum_q, csum_d;

    logic              w_hs;
    logic              w_eof;
    logic [16:0]       w_rem17;
    logic [7:0]        w_ll;
    logic [15:0]       w_hdr_addr;
    logic [7:0]        w_chk;
    logic [7:0]        w_byte;
    logic              w_consume;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_hs   = out_valid_q && out_ready;
    assign w_eof  = (rem_q == '0);
    assign w_chk  = 8'd0 - csum_q;
    // A byte not yet captured is still readable straight off the memory bus.
    assign w_byte = pf_valid_q ? pf_q : mem_data;

    always_comb begin
        w_rem17 = '0;
        w_rem17[ADDR_W:0] = rem_q;
        w_ll = (w_rem17 > c_REC_LEN17) ? c_REC_LEN8 : w_rem17[7:0];
    end

    // The EOF record always carries address 0000.
    always_comb begin
        w_hdr_addr = '0;
        if (!w_eof) begin
            w_hdr_addr[ADDR_W-1:0] = fetch_addr_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            rem_q         <= '0;
            fetch_addr_q  <= '0;
            addr_stable_q <= 1'b0;
            pf_q          <= 8'h00;
            pf_valid_q    <= 1'b0;
            cur_q         <= 8'h00;
            rec_cnt_q     <= 8'h00;
            ll_q          <= 8'h00;
            eof_q         <= 1'b0;
            csum_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            rem_q         <= rem_d;
            fetch_addr_q  <= fetch_addr_d;
            addr_stable_q <= addr_stable_d;
            pf_q          <= pf_d;
            pf_valid_q    <= pf_valid_d;
            cur_q         <= cur_d;
            rec_cnt_q     <= rec_cnt_d;
            ll_q          <= ll_d;
            eof_q         <= eof_d;
            csum_q        <= csum_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        rem_d         = rem_q;
        fetch_addr_d  = fetch_addr_q;
        addr_stable_d = 1'b1;
        pf_d          = pf_q;
        pf_valid_d    = pf_valid_q;
        cur_d         = cur_q;
        rec_cnt_d     = rec_cnt_q;
        ll_d          = ll_q;
        eof_d         = eof_q;
        csum_d        = csum_q;
        w_consume     = 1'b0;

        // mem_data is trustworthy once the address has been held for a cycle.
        if ((state_q != IDLE) && (state_q != FIN) && !pf_valid_q &&
            addr_stable_q && (rem_q != '0)) begin
            pf_d       = mem_data;
            pf_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = COLON;
                    out_valid_d   = 1'b1;
                    out_data_d    = c_CH_COLON;
                    rem_d         = len;
                    fetch_addr_d  = base_addr;
                    addr_stable_d = 1'b0;
                    pf_valid_d    = 1'b0;
                end
            end
            COLON: begin
                if (w_hs) begin
                    state_d    = LEN_H;
                    out_data_d = hex(w_ll[7:4]);
                    ll_d       = w_ll;
                    rec_cnt_d  = w_ll;
                    eof_d      = w_eof;
                    csum_d     = w_ll + w_hdr_addr[15:8] + w_hdr_addr[7:0] + {7'd0, w_eof};
                end
            end
            LEN_H: if (w_hs) begin state_d = LEN_L; out_data_d = hex(ll_q[3:0]);         end
            LEN_L: if (w_hs) begin state_d = ADR3;  out_data_d = hex(w_hdr_addr[15:12]); end
            ADR3:  if (w_hs) begin state_d = ADR2;  out_data_d = hex(w_hdr_addr[11:8]);  end
            ADR2:  if (w_hs) begin state_d = ADR1;  out_data_d = hex(w_hdr_addr[7:4]);   end
            ADR1:  if (w_hs) begin state_d = ADR0;  out_data_d = hex(w_hdr_addr[3:0]);   end
            ADR0:  if (w_hs) begin state_d = TYP_H; out_data_d = c_CH_ZERO;              end
            TYP_H: begin
                if (w_hs) begin
                    state_d    = TYP_L;
                    out_data_d = eof_q ? c_CH_ONE : c_CH_ZERO;
                end
            end
            TYP_L: begin
                if (w_hs) begin
                    if (eof_q) begin
                        state_d    = CHK_H;
                        out_data_d = hex(w_chk[7:4]);
                    end else begin
                        state_d   = DAT_H;
                        w_consume = 1'b1;
                    end
                end
            end
            DAT_H: if (w_hs) begin state_d = DAT_L; out_data_d = hex(cur_q[3:0]); end
            DAT_L: begin
                if (w_hs) begin
                    if (rec_cnt_q != 8'd0) begin
                        state_d   = DAT_H;
                        w_consume = 1'b1;
                    end else begin
                        state_d    = CHK_H;
                        out_data_d = hex(w_chk[7:4]);
                    end
                end
            end
            CHK_H: if (w_hs) begin state_d = CHK_L; out_data_d = hex(w_chk[3:0]); end
            CHK_L: begin
                if (w_hs) begin
`ifdef HEX_DUMPER_CRLF_EN
                    state_d    = EOL_CR;
                    out_data_d = c_CH_CR;
`else
                    state_d    = EOL_LF;
                    out_data_d = c_CH_LF;
`endif
                end
            end
            EOL_CR: if (w_hs) begin state_d = EOL_LF; out_data_d = c_CH_LF; end
            EOL_LF: begin
                if (w_hs) begin
                    if (!eof_q) begin
                        state_d    = COLON;
                        out_data_d = c_CH_COLON;
                    end else begin
                        state_d     = FIN;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Moving a byte into DAT_H frees the prefetch slot and steps the read address.
        if (w_consume) begin
            cur_d         = w_byte;
            out_data_d    = hex(w_byte[7:4]);
            csum_d        = csum_q + w_byte;
            rec_cnt_d     = rec_cnt_q - 8'd1;
            rem_d         = rem_q - (ADDR_W+1)'(1);
            fetch_addr_d  = fetch_addr_q + ADDR_W'(1);
            addr_stable_d = 1'b0;
            pf_valid_d    = 1'b0;
        end
    end

    assign mem_addr  = fetch_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE) && (state_q != FIN);
    assign done      = (state_q == FIN);

endmodule

`default_nettype wire

// File: tb/tb_hex_dumper.sv
// Directed bench for hex_dumper: captures every accepted character and compares
// each stream against hand-written Intel HEX text.
`timescale 1ns/1ps
`default_nettype none

module tb_hex_dumper;

    localparam int ADDR_W = 15;
    localparam int REC_LEN = 16;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    hex_dumper #(.ADDR_W(ADDR_W), .REC_LEN(REC_LEN)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk_sys) mem_data <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    logic [7:0] cap [0:1023];
    int         cap_cyc [0:1023];
    int         cap_n = 0;
    int         done_cnt = 0;
    int         busy_at_done = 0;

    always @(negedge clk_sys) begin
        if (out_valid && out_ready && cap_n < 1024) begin
            cap[cap_n]     = out_data;
            cap_cyc[cap_n] = cyc;
            cap_n++;
        end
        if (done) begin
            done_cnt++;
            if (busy) busy_at_done++;
        end
    end

    int    checks = 0;
    int    errors = 0;
    string eol;

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        @(posedge clk_sys); #1;
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(posedge clk_sys); #1;
        start     = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; len = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        @(posedge clk_sys); #1; reset = 1'b0;
    endtask

    task automatic test_basic;
        string exp;
        int b0, d0, n, bad, s_cyc;
        exp = {":020000000C945E", eol, ":00000001FF", eol};
        mem[0] = 8'h0C; mem[1] = 8'h94;
        b0 = cap_n; d0 = done_cnt;
        pulse_start(15'h0000, 16'd2);
        s_cyc = cyc;
        for (int k = 0; k < 500 && done_cnt == d0; k++) @(negedge clk_sys);
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL basic_done timeout got 0 want 1 pulse"); end
        repeat (4) @(negedge clk_sys);
        n = cap_n - b0;
        checks++; if (n != exp.len()) begin errors++; $display("FAIL basic_count got %0d want %0d", n, exp.len()); end
        bad = -1;
        for (int i = 0; i < exp.len() && i < n; i++) if (bad < 0 && cap[b0+i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL basic_stream idx %0d got %h want %h", bad, cap[b0+bad], exp[bad]); end
        if (n > 0) begin
            checks++; if (cap_cyc[b0] != s_cyc) begin errors++; $display("FAIL basic_first_cycle got %0d want %0d", cap_cyc[b0], s_cyc); end
            checks++; if (cap_cyc[b0+n-1] - cap_cyc[b0] != n - 1) begin
                errors++; $display("FAIL basic_no_bubbles got span %0d want %0d", cap_cyc[b0+n-1] - cap_cyc[b0], n - 1);
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt - d0); end
        mem[0] = 8'h00; mem[1] = 8'h01;
    endtask

    task automatic test_len0;
        string exp;
        int b0, d0, n, bad;
        exp = {":00000001FF", eol};
        b0 = cap_n; d0 = done_cnt;
        pulse_start(15'h1234, 16'd0);
        for (int k = 0; k < 200 && done_cnt == d0; k++) @(negedge clk_sys);
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL len0_done timeout got 0 want 1 pulse"); end
        repeat (4) @(negedge clk_sys);
        n = cap_n - b0;
        checks++; if (n != exp.len()) begin errors++; $display("FAIL len0_count got %0d want %0d", n, exp.len()); end
        bad = -1;
        for (int i = 0; i < exp.len() && i < n; i++) if (bad < 0 && cap[b0+i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL len0_stream idx %0d got %h want %h", bad, cap[b0+bad], exp[bad]); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL len0_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap;
        string exp;
        int b0, d0, n, bad;
        exp = {":107FF800F8F9FAFBFCFDFEFF000102030405060781", eol,
               ":0100080008EF", eol, ":00000001FF", eol};
        b0 = cap_n; d0 = done_cnt;
        pulse_start(15'h7FF8, 16'd17);
        for (int k = 0; k < 500 && done_cnt == d0; k++) @(negedge clk_sys);
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL wrap_done timeout got 0 want 1 pulse"); end
        repeat (4) @(negedge clk_sys);
        n = cap_n - b0;
        checks++; if (n != exp.len()) begin errors++; $display("FAIL wrap_count got %0d want %0d", n, exp.len()); end
        bad = -1;
        for (int i = 0; i < exp.len() && i < n; i++) if (bad < 0 && cap[b0+i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL wrap_stream idx %0d got %h want %h", bad, cap[b0+bad], exp[bad]); end
    endtask

    task automatic test_stall;
        string exp;
        int b0, d0, n, bad;
        exp = {":020010001011CD", eol, ":00000001FF", eol};
        b0 = cap_n; d0 = done_cnt;
        pulse_start(15'h0010, 16'd2);
        repeat (9) @(posedge clk_sys);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin
                errors++; $display("FAIL stall_hold cyc %0d got v=%b d=%h want v=1 d=31", k, out_valid, out_data);
            end
            checks++; if (mem_addr !== 15'h0010 && mem_addr !== 15'h0011) begin
                errors++; $display("FAIL stall_prefetch cyc %0d got addr %h want 0010 or 0011", k, mem_addr);
            end
        end
        @(posedge clk_sys); #1 out_ready = 1'b1;
        for (int k = 0; k < 500 && done_cnt == d0; k++) @(negedge clk_sys);
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL stall_done timeout got 0 want 1 pulse"); end
        repeat (4) @(negedge clk_sys);
        n = cap_n - b0;
        checks++; if (n != exp.len()) begin errors++; $display("FAIL stall_count got %0d want %0d", n, exp.len()); end
        bad = -1;
        for (int i = 0; i < exp.len() && i < n; i++) if (bad < 0 && cap[b0+i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL stall_stream idx %0d got %h want %h", bad, cap[b0+bad], exp[bad]); end
    endtask

    task automatic test_reset_mid;
        string exp;
        int b0, d0, n, bad;
        exp = {":020010001011CD", eol, ":00000001FF", eol};
        d0 = done_cnt;
        pulse_start(15'h0020, 16'd4);
        repeat (10) @(posedge clk_sys);
        #1 reset = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); end
        @(posedge clk_sys); #1 reset = 1'b0;
        b0 = cap_n; d0 = done_cnt;
        pulse_start(15'h0010, 16'd2);
        for (int k = 0; k < 500 && done_cnt == d0; k++) @(negedge clk_sys);
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL rstmid_done timeout got 0 want 1 pulse"); end
        repeat (4) @(negedge clk_sys);
        n = cap_n - b0;
        checks++; if (n != exp.len()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", n, exp.len()); end
        bad = -1;
        for (int i = 0; i < exp.len() && i < n; i++) if (bad < 0 && cap[b0+i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL rstmid_stream idx %0d got %h want %h", bad, cap[b0+bad], exp[bad]); end
    endtask

    task automatic test_back_to_back;
        string exp;
        int b0, d0, n, bad;
        exp = {":020010001011CD", eol, ":00000001FF", eol};
        b0 = cap_n; d0 = done_cnt;
        pulse_start(15'h0010, 16'd2);
        repeat (3) @(posedge clk_sys);
        pulse_start(15'h0040, 16'd5);
        for (int k = 0; k < 500 && done_cnt == d0; k++) @(negedge clk_sys);
        checks++; if (done_cnt == d0) begin errors++; $display("FAIL b2b_done timeout got 0 want 1 pulse"); end
        repeat (20) @(negedge clk_sys);
        n = cap_n - b0;
        checks++; if (n != exp.len()) begin errors++; $display("FAIL b2b_count got %0d want %0d", n, exp.len()); end
        bad = -1;
        for (int i = 0; i < exp.len() && i < n; i++) if (bad < 0 && cap[b0+i] !== exp[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL b2b_stream idx %0d got %h want %h", bad, cap[b0+bad], exp[bad]); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (busy_at_done != 0) begin errors++; $display("FAIL busy_at_done got %0d want 0", busy_at_done); end
    endtask

    initial begin
`ifdef HEX_DUMPER_CRLF_EN
        eol = "\015\012";
`else
        eol = "\012";
`endif
        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'(a);
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
